// File: rtl/my_mux_8_way_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : my_mux_8_way_arbiter_if
// Description : Bundle of eight valid/ready source channels plus one
//               registered output stream for the 8-way round-robin merger.
//               master : the merger side (takes sources, drives output)
//               slave  : the environment side (drives sources, consumes)
// Signals     : in_valid[8], in_data[8*WIDTH], in_ready[8],
//               out_valid, out_data[WIDTH], out_sel[3], out_ready
// Revision    : 1.0 - initial release
// ============================================================================
interface my_mux_8_way_arbiter_if #(
   parameter int WIDTH = 16
);
   logic [7:0]         in_valid;
   logic [8*WIDTH-1:0] in_data;
   logic [7:0]         in_ready;
   logic               out_valid;
   logic [WIDTH-1:0]   out_data;
   logic [2:0]         out_sel;
   logic               out_ready;

   modport master (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_sel
   );

   modport slave (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_sel
   );
endinterface
`default_nettype wire

// File: rtl/my_mux_8_way_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : my_mux_8_way_arbiter
// Description : Eight-input round-robin merger. Pulls one word per cycle from
//               eight valid/ready source channels into a single registered
//               output stream; each output word is tagged with its 3-bit
//               source index (same encoding as an 8-way demux select).
// Ports       : clk  - rising-edge clock
//               rst  - asynchronous active-high reset
//               bus  - my_mux_8_way_arbiter_if.master
//                      in_valid/in_data/in_ready : source channels
//                      out_valid/out_data/out_sel/out_ready : output stream
// Notes       : WIDTH must match the WIDTH of the connected interface.
//               in_ready is combinational from in_valid and out_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module my_mux_8_way_arbiter #(
   parameter int WIDTH = 16
) (
   input wire                     clk,
   input wire                     rst,
   my_mux_8_way_arbiter_if.master bus
);

   // Arbitration state and output register
   logic [2:0]       r_ptr;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic [2:0]       r_out_sel;

   // Combinational grant path
   logic             w_found;
   logic [2:0]       w_grant;
   logic [2:0]       w_idx;
   logic             w_load;
   logic             w_accept;
   logic [WIDTH-1:0] w_word;

   // Round-robin scan starting at r_ptr. Walking the offsets from 7 down to
   // 0 lets the lowest offset (closest to r_ptr) overwrite earlier hits, so
   // the final value is the first valid channel in priority order.
   always_comb begin
      w_found = 1'b0;
      w_grant = 3'd0;
      w_idx   = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         w_idx = r_ptr + 3'(k);
         if (bus.in_valid[w_idx]) begin
            w_found = 1'b1;
            w_grant = w_idx;
         end
      end
   end

   // The output register can take a new word when empty or being drained.
   assign w_load   = ~r_out_valid | bus.out_ready;
   // rst gating keeps in_ready low while reset is held, so no source sees a
   // handshake that the register would then discard.
   assign w_accept = w_found & w_load & ~rst;

   assign w_word = bus.in_data[w_grant*WIDTH +: WIDTH];

   assign bus.in_ready  = w_accept ? (8'b1 << w_grant) : 8'b0;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_sel   = r_out_sel;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr       <= 3'd0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sel   <= 3'd0;
      end else if (w_accept) begin
         // A new word replaces any word being drained this same edge.
         r_out_valid <= 1'b1;
         r_out_data  <= w_word;
         r_out_sel   <= w_grant;
         r_ptr       <= w_grant + 3'd1;
      end else if (bus.out_ready) begin
         // Drain with nothing to load: data and sel keep their old values.
         r_out_valid <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_my_mux_8_way_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_my_mux_8_way_arbiter
// Description : Self-checking bench for the 8-way round-robin merger.
//               Expected output words are queued when stimulus is driven and
//               popped when the output register presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_my_mux_8_way_arbiter;

   localparam int WIDTH = 16;

   logic clk = 1'b0;
   logic rst;

   my_mux_8_way_arbiter_if #(.WIDTH(WIDTH)) bus ();

   my_mux_8_way_arbiter #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]       sel;
      logic [WIDTH-1:0] data;
   } exp_t;

   exp_t             sb[$];
   int               errors = 0;
   int               checks = 0;
   logic [WIDTH-1:0] word [8];

   // Drive source valids/words and the consumer ready.
   task automatic apply(input logic [7:0] v, input logic ordy);
      bus.in_valid  = v;
      bus.out_ready = ordy;
      for (int i = 0; i < 8; i++) bus.in_data[i*WIDTH +: WIDTH] = word[i];
   endtask

   // Next expected word; an empty queue yields X so the comparison fails.
   function automatic exp_t take();
      exp_t e;
      if (sb.size() == 0) e = 'x;
      else e = sb.pop_front();
      return e;
   endfunction

   task automatic test_reset;
      rst = 1'b1;
      for (int i = 0; i < 8; i++) word[i] = 16'hA5A5;
      apply(8'hFF, 1'b1);
      @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.out_sel, bus.out_data} !== '0) begin
         errors++;
         $display("FAIL reset_out: got v=%0b sel=%0d data=%h want 0/0/0000",
                  bus.out_valid, bus.out_sel, bus.out_data);
      end
      checks++;
      if (bus.in_ready !== 8'h00) begin
         errors++;
         $display("FAIL reset_in_ready: got %b want 00000000", bus.in_ready);
      end
      rst = 1'b0;
      apply(8'h00, 1'b1);
   endtask

   task automatic test_contention;
      exp_t e;
      for (int i = 0; i < 8; i++) word[i] = 16'(i) * 16'h0101;
      apply(8'hFF, 1'b1);
      for (int i = 0; i < 9; i++) begin
         #1;
         checks++;
         if (bus.in_ready !== 8'(1 << (i % 8))) begin
            errors++;
            $display("FAIL contention_ready[%0d]: got %b want %b", i, bus.in_ready, 8'(1 << (i % 8)));
         end
         sb.push_back('{sel: 3'(i % 8), data: 16'(i % 8) * 16'h0101});
         @(negedge clk);
         e = take();
         checks++;
         if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b1, e.sel, e.data}) begin
            errors++;
            $display("FAIL contention_out[%0d]: got v=%0b sel=%0d data=%h want v=1 sel=%0d data=%h",
                     i, bus.out_valid, bus.out_sel, bus.out_data, e.sel, e.data);
         end
      end
   endtask

   // Entry: ptr=1, output holds channel 0.
   task automatic test_idle_drain;
      exp_t e;
      word[3] = 16'h3C3C;
      apply(8'b0000_1000, 1'b1);
      #1;
      checks++;
      if (bus.in_ready !== 8'b0000_1000) begin
         errors++;
         $display("FAIL drain_load_ready: got %b want 00001000", bus.in_ready);
      end
      sb.push_back('{sel: 3'd3, data: 16'h3C3C});
      @(negedge clk);
      e = take();
      checks++;
      if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b1, e.sel, e.data}) begin
         errors++;
         $display("FAIL drain_load_out: got v=%0b sel=%0d data=%h want v=1 sel=%0d data=%h",
                  bus.out_valid, bus.out_sel, bus.out_data, e.sel, e.data);
      end
      apply(8'h00, 1'b1);
      #1;
      checks++;
      if (bus.in_ready !== 8'h00) begin
         errors++;
         $display("FAIL drain_idle_ready: got %b want 00000000", bus.in_ready);
      end
      @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b0, 3'd3, 16'h3C3C}) begin
         errors++;
         $display("FAIL drain_out: got v=%0b sel=%0d data=%h want v=0 sel=3 data=3c3c",
                  bus.out_valid, bus.out_sel, bus.out_data);
      end
      // ptr must still be 4: with channels 3 and 5 valid, channel 5 wins.
      word[3] = 16'h3333;
      word[5] = 16'h5A5A;
      apply(8'b0010_1000, 1'b1);
      #1;
      checks++;
      if (bus.in_ready !== 8'b0010_0000) begin
         errors++;
         $display("FAIL drain_ptr_hold: got %b want 00100000", bus.in_ready);
      end
      sb.push_back('{sel: 3'd5, data: 16'h5A5A});
      @(negedge clk);
      e = take();
      checks++;
      if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b1, e.sel, e.data}) begin
         errors++;
         $display("FAIL drain_ptr_out: got v=%0b sel=%0d data=%h want v=1 sel=%0d data=%h",
                  bus.out_valid, bus.out_sel, bus.out_data, e.sel, e.data);
      end
   endtask

   // Entry: ptr=6. Channel 3 still holds an unaccepted word; drop it first.
   task automatic test_sparse_wrap;
      exp_t        e;
      logic [7:0]  v_seq [3];
      logic [7:0]  r_seq [3];
      logic [15:0] w7_seq[3];
      v_seq  = '{8'b1000_0100, 8'b1000_0100, 8'b1000_0000};
      r_seq  = '{8'b1000_0000, 8'b0000_0100, 8'b1000_0000};
      w7_seq = '{16'h7777, 16'h7A7A, 16'h7A7A};
      word[2] = 16'h2222;
      for (int i = 0; i < 3; i++) begin
         word[7] = w7_seq[i];
         apply(v_seq[i], 1'b1);
         #1;
         checks++;
         if (bus.in_ready !== r_seq[i]) begin
            errors++;
            $display("FAIL wrap_ready[%0d]: got %b want %b", i, bus.in_ready, r_seq[i]);
         end
         sb.push_back('{sel: (r_seq[i][7] ? 3'd7 : 3'd2), data: (r_seq[i][7] ? w7_seq[i] : 16'h2222)});
         @(negedge clk);
         e = take();
         checks++;
         if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b1, e.sel, e.data}) begin
            errors++;
            $display("FAIL wrap_out[%0d]: got v=%0b sel=%0d data=%h want v=1 sel=%0d data=%h",
                     i, bus.out_valid, bus.out_sel, bus.out_data, e.sel, e.data);
         end
      end
   endtask

   // Entry: ptr=0.
   task automatic test_backpressure;
      exp_t e;
      word[4] = 16'hBEEF;
      apply(8'b0001_0000, 1'b1);
      #1;
      sb.push_back('{sel: 3'd4, data: 16'hBEEF});
      @(negedge clk);
      e = take();
      checks++;
      if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b1, e.sel, e.data}) begin
         errors++;
         $display("FAIL bp_load_out: got v=%0b sel=%0d data=%h want v=1 sel=%0d data=%h",
                  bus.out_valid, bus.out_sel, bus.out_data, e.sel, e.data);
      end
      word[1] = 16'h1111;
      apply(8'b0000_0010, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (bus.in_ready !== 8'h00) begin
            errors++;
            $display("FAIL bp_ready[%0d]: got %b want 00000000", i, bus.in_ready);
         end
         @(negedge clk);
         checks++;
         if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b1, 3'd4, 16'hBEEF}) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got v=%0b sel=%0d data=%h want v=1 sel=4 data=beef",
                     i, bus.out_valid, bus.out_sel, bus.out_data);
         end
      end
      apply(8'b0000_0010, 1'b1);
      #1;
      checks++;
      if (bus.in_ready !== 8'b0000_0010) begin
         errors++;
         $display("FAIL bp_release_ready: got %b want 00000010", bus.in_ready);
      end
      sb.push_back('{sel: 3'd1, data: 16'h1111});
      @(negedge clk);
      e = take();
      checks++;
      if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b1, e.sel, e.data}) begin
         errors++;
         $display("FAIL bp_release_out: got v=%0b sel=%0d data=%h want v=1 sel=%0d data=%h",
                  bus.out_valid, bus.out_sel, bus.out_data, e.sel, e.data);
      end
   endtask

   // Entry: ptr=2.
   task automatic test_reset_mid;
      exp_t e;
      word[5] = 16'h5555;
      apply(8'b0010_0000, 1'b1);
      #1;
      sb.push_back('{sel: 3'd5, data: 16'h5555});
      @(negedge clk);
      e = take();
      checks++;
      if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b1, e.sel, e.data}) begin
         errors++;
         $display("FAIL rstmid_setup: got v=%0b sel=%0d data=%h want v=1 sel=%0d data=%h",
                  bus.out_valid, bus.out_sel, bus.out_data, e.sel, e.data);
      end
      // Holding channel 5 with ptr=6; reset between edges.
      apply(8'h00, 1'b0);
      #1;
      word[0] = 16'h0A0A;
      word[3] = 16'h0D0D;
      rst = 1'b1;
      apply(8'b0000_1001, 1'b1);
      #1;
      checks++;
      if ({bus.out_valid, bus.out_sel, bus.out_data} !== '0) begin
         errors++;
         $display("FAIL rstmid_out: got v=%0b sel=%0d data=%h want 0/0/0000",
                  bus.out_valid, bus.out_sel, bus.out_data);
      end
      checks++;
      if (bus.in_ready !== 8'h00) begin
         errors++;
         $display("FAIL rstmid_ready: got %b want 00000000", bus.in_ready);
      end
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (bus.in_ready !== 8'b0000_0001) begin
         errors++;
         $display("FAIL rstmid_first_grant: got %b want 00000001", bus.in_ready);
      end
      sb.push_back('{sel: 3'd0, data: 16'h0A0A});
      @(negedge clk);
      e = take();
      checks++;
      if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b1, e.sel, e.data}) begin
         errors++;
         $display("FAIL rstmid_out0: got v=%0b sel=%0d data=%h want v=1 sel=%0d data=%h",
                  bus.out_valid, bus.out_sel, bus.out_data, e.sel, e.data);
      end
      apply(8'b0000_1000, 1'b1);
      #1;
      sb.push_back('{sel: 3'd3, data: 16'h0D0D});
      @(negedge clk);
      e = take();
      checks++;
      if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b1, e.sel, e.data}) begin
         errors++;
         $display("FAIL rstmid_out3: got v=%0b sel=%0d data=%h want v=1 sel=%0d data=%h",
                  bus.out_valid, bus.out_sel, bus.out_data, e.sel, e.data);
      end
   endtask

   // Randomised sources; output strobe demuxed by out_sel back onto lanes.
   task automatic test_round_trip;
      exp_t       e;
      int         seq[8], exp_seq[8], wait_cnt[8];
      int         m_ptr, g, s;
      bit         m_ov, found, load, pushed;
      logic [7:0] v, v_acc, exp_rdy, lane;
      logic       ordy;
      apply(8'h00, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      m_ptr = 0;
      m_ov  = 1'b0;
      v     = 8'h00;
      v_acc = 8'h00;
      for (int i = 0; i < 8; i++) begin
         seq[i] = 0; exp_seq[i] = 0; wait_cnt[i] = 0;
      end
      for (int cyc = 0; cyc < 300; cyc++) begin
         for (int i = 0; i < 8; i++) begin
            if (!v[i] && $urandom_range(0, 1) == 1) begin
               v[i]    = 1'b1;
               word[i] = {3'(i), 13'(seq[i])};
            end
         end
         ordy = ($urandom_range(0, 3) != 0);
         apply(v, ordy);
         #1;
         load  = !m_ov || ordy;
         found = 1'b0;
         g     = 0;
         for (int k = 0; k < 8; k++) begin
            if (!found && v[(m_ptr + k) % 8]) begin
               found = 1'b1;
               g     = (m_ptr + k) % 8;
            end
         end
         exp_rdy = (found && load) ? 8'(1 << g) : 8'h00;
         checks++;
         if (bus.in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL rt_ready[%0d]: got %b want %b", cyc, bus.in_ready, exp_rdy);
         end
         pushed = found && load;
         if (pushed) begin
            sb.push_back('{sel: 3'(g), data: word[g]});
            v_acc  = v;
            m_ptr  = (g + 1) % 8;
            m_ov   = 1'b1;
            v[g]   = 1'b0;
            seq[g] = seq[g] + 1;
         end else if (ordy) begin
            m_ov = 1'b0;
         end
         @(negedge clk);
         if (pushed) begin
            e = take();
            checks++;
            if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b1, e.sel, e.data}) begin
               errors++;
               $display("FAIL rt_out[%0d]: got v=%0b sel=%0d data=%h want v=1 sel=%0d data=%h",
                        cyc, bus.out_valid, bus.out_sel, bus.out_data, e.sel, e.data);
            end
            lane = bus.out_valid ? (8'b1 << bus.out_sel) : 8'b0;
            checks++;
            if (lane !== (8'b1 << e.sel)) begin
               errors++;
               $display("FAIL rt_lane[%0d]: got %b want %b", cyc, lane, 8'b1 << e.sel);
            end
            s = int'(bus.out_sel);
            checks++;
            if (bus.out_data[12:0] !== 13'(exp_seq[s])) begin
               errors++;
               $display("FAIL rt_order[%0d]: lane %0d got seq %0d want %0d",
                        cyc, s, bus.out_data[12:0], exp_seq[s]);
            end
            exp_seq[s] = exp_seq[s] + 1;
            checks++;
            if (wait_cnt[s] > 7) begin
               errors++;
               $display("FAIL rt_fair[%0d]: lane %0d waited %0d accepts want <=7", cyc, s, wait_cnt[s]);
            end
            wait_cnt[s] = 0;
            for (int i = 0; i < 8; i++)
               if (i != s && v_acc[i]) wait_cnt[i] = wait_cnt[i] + 1;
         end else begin
            checks++;
            if (bus.out_valid !== m_ov) begin
               errors++;
               $display("FAIL rt_valid[%0d]: got %0b want %0b", cyc, bus.out_valid, m_ov);
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bus.in_valid  = 8'h00;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      test_reset();
      test_contention();
      test_idle_drain();
      test_sparse_wrap();
      test_backpressure();
      test_reset_mid();
      test_round_trip();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
